phase_sequencer: RTL and testbench

- Sequences the traffic-phase datapath.
- Owns the phase state machine (G green, A amber, E red/walk, L all-red clearance) and a 6-bit phase down-counter.
- Drives state/specific/pulse to the preset generator, loads the returned preset, counts it down on 1 Hz ticks and advances phases.
- Latches pedestrian requests, which preempt green and lengthen amber.

---
 rtl/phase_sequencer_pkg.sv | 20 ++
 rtl/phase_sequencer_if.sv | 28 ++
 rtl/phase_timer.sv | 29 ++
 rtl/phase_sequencer.sv | 98 +++++++++
 tb/tb_phase_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared encodings for the traffic-phase sequencer: phase codes, lamp codes
// and the nominal phase durations in seconds.
package phase_sequencer_pkg;

  localparam logic [1:0] ST_E = 2'b00;
  localparam logic [1:0] ST_A = 2'b01;
  localparam logic [1:0] ST_G = 2'b10;
  localparam logic [1:0] ST_L = 2'b11;

  localparam logic [2:0] LT_GREEN = 3'b001;
  localparam logic [2:0] LT_AMBER = 3'b010;
  localparam logic [2:0] LT_RED   = 3'b100;

  localparam int D_G  = 30;
  localparam int D_A  = 15;
  localparam int D_AS = 22;
  localparam int D_E  = 30;
  localparam int D_L  = 5;

endpackage

// File: rtl/phase_sequencer_if.sv
// Bundle between the phase sequencer and its surroundings (tick source,
// pedestrian input, preset generator, lamp drivers).
interface phase_sequencer_if #(
  parameter int CW = 6
);
  // Load handshake: pulse is a one-cycle valid with no ready; the generator
  // must present preset combinationally from state/specific while pulse=1,
  // and the sequencer captures it on the edge that ends the pulse cycle.
  logic          tick;
  logic          req;
  logic [CW-1:0] preset;
  logic [1:0]    state;
  logic          specific;
  logic          pulse;
  logic [CW-1:0] count;
  logic [2:0]    lights;
  logic          walk;

  modport master (
    input  tick, req, preset,
    output state, specific, pulse, count, lights, walk
  );

  modport slave (
    output tick, req, preset,
    input  state, specific, pulse, count, lights, walk
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter for the phase duration; 'last' flags the tick that
// ends the phase. Never wraps below zero.
module phase_timer
  import phase_sequencer_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] value,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = tick && (count <= CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick) begin
      count <= last ? '0 : count - CW'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Phase state machine G->A->E->L->G with preset load handshake, pedestrian
// request latch, green preemption and lamp decode.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int CW         = 6,
  parameter int PREEMPT_AT = 20
) (
  input  logic clk,
  input  logic reset,
  phase_sequencer_if.master bus
);

  localparam logic [CW-1:0] PRE_LIM = CW'(PREEMPT_AT);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          pulse;
  logic          load_req;
  logic          pending;
  logic          busy;
  logic          tick_eff;
  logic          last;
  logic          preempt;
  logic          advance;
  logic          timer_load;
  logic [CW-1:0] timer_value;
  logic [CW-1:0] count;

  // A tick arriving while a load is outstanding is dropped: the load wins.
  assign busy     = pulse | load_req;
  assign tick_eff = bus.tick & ~busy;
  assign preempt  = (state == ST_G) & pending & tick_eff & (count <= PRE_LIM);
  assign advance  = last | preempt;

  // Preempting green also zeroes the count so every phase end looks alike.
  assign timer_load  = pulse | preempt;
  assign timer_value = pulse ? bus.preset : '0;

  phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .tick  (tick_eff),
    .count (count),
    .last  (last)
  );

  always_comb begin
    state_next = ST_L;
    case (state)
      ST_G:    state_next = ST_A;
      ST_A:    state_next = ST_E;
      ST_E:    state_next = ST_L;
      ST_L:    state_next = ST_G;
      default: state_next = ST_L;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_L;
      pulse    <= 1'b0;
      load_req <= 1'b1;
      pending  <= 1'b0;
    end else begin
      load_req <= 1'b0;
      pulse    <= load_req | advance;
      if (advance) begin
        state <= state_next;
      end
      // A request on the E-entry edge survives the clear.
      if (bus.req) begin
        pending <= 1'b1;
      end else if (advance && (state_next == ST_E)) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.lights = LT_RED;
    case (state)
      ST_G:    bus.lights = LT_GREEN;
      ST_A:    bus.lights = LT_AMBER;
      default: bus.lights = LT_RED;
    endcase
  end

  // The generator has no defined green preset for a pending request.
  assign bus.specific = pending & (state != ST_G);
  assign bus.walk     = (state == ST_E);
  assign bus.state    = state;
  assign bus.pulse    = pulse;
  assign bus.count    = count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus random ticks/requests,
// checked cycle by cycle and at every load against a phase-level model.
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;

  localparam int CW      = 6;
  localparam int PREEMPT = 20;
  localparam int W       = 1 + 2 + 1 + CW + 3 + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  phase_sequencer_if #(.CW(CW)) bus ();

  phase_sequencer #(.CW(CW), .PREEMPT_AT(PREEMPT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Preset generator stand-in: garbage whenever pulse is low.
  logic [CW-1:0] junk = '0;
  always @(negedge clk) junk <= CW'($urandom_range(0, 63));

  always @* begin
    if (!bus.pulse) bus.preset = junk;
    else begin
      case (bus.state)
        ST_G:    bus.preset = CW'(D_G);
        ST_A:    bus.preset = bus.specific ? CW'(D_AS) : CW'(D_A);
        ST_E:    bus.preset = CW'(D_E);
        default: bus.preset = CW'(D_L);
      endcase
    end
  end

  // Reference model: phase index 0..3 walks G,A,E,L in order.
  logic [1:0] order [4] = '{ST_G, ST_A, ST_E, ST_L};
  int m_idx, m_count, m_load_val;
  bit m_pending, m_loading, m_boot;

  logic [W-1:0] exp_q[$];
  int           load_q[$];

  function automatic int dur_of(input int idx, input bit spec);
    case (idx)
      0:       return D_G;
      1:       return spec ? D_AS : D_A;
      2:       return D_E;
      default: return D_L;
    endcase
  endfunction

  function automatic logic [2:0] lights_of(input int idx);
    if (idx == 0) return LT_GREEN;
    if (idx == 1) return LT_AMBER;
    return LT_RED;
  endfunction

  function automatic logic [W-1:0] snap();
    return {m_loading, order[m_idx], (m_pending && (m_idx != 0)), CW'(m_count),
            lights_of(m_idx), (m_idx == 2)};
  endfunction

  task automatic model_reset();
    m_idx = 3; m_count = 0; m_pending = 1'b0; m_loading = 1'b0; m_boot = 1'b1;
    m_load_val = 0;
    exp_q.delete();
    load_q.delete();
  endtask

  task automatic model_edge(input bit t, input bit r);
    bit enter_e;
    enter_e = 1'b0;
    if (m_loading) begin
      m_count = m_load_val;
      m_loading = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_loading = 1'b1;
    end else if (t) begin
      if (m_count <= 1 || (m_idx == 0 && m_pending && m_count <= PREEMPT)) begin
        m_count = 0;
        m_idx = (m_idx + 1) % 4;
        m_loading = 1'b1;
        enter_e = (m_idx == 2);
      end else begin
        m_count = m_count - 1;
      end
    end
    if (r) m_pending = 1'b1;
    else if (enter_e) m_pending = 1'b0;
    if (m_loading) begin
      m_load_val = dur_of(m_idx, m_pending && (m_idx != 0));
      load_q.push_back(m_load_val);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver tasks
  task automatic cycle(input bit t, input bit r);
    @(negedge clk);
    bus.tick = t;
    bus.req  = r;
    @(posedge clk);
    model_edge(t, r);
    exp_q.push_back(snap());
  endtask

  task automatic sec(input bit r);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, r);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
    bus.tick = 1'b0;
    bus.req  = 1'b0;
    model_reset();
    #1;
    check("rst_state", bus.state, ST_L);
    check("rst_count", bus.count, 0);
    check("rst_pulse", bus.pulse, 0);
    check("rst_lights", bus.lights, LT_RED);
    check("rst_walk", bus.walk, 0);
    check("rst_specific", bus.specific, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic boot_sequence();
    cycle(1'b0, 1'b0);
    #1 check("boot_pulse", bus.pulse, 1);
    cycle(1'b0, 1'b0);
    #1 check("boot_count", bus.count, D_L);
    check("boot_pulse_low", bus.pulse, 0);
    check("boot_lights", bus.lights, LT_RED);
    repeat (5) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("first_g_state", bus.state, ST_G);
    check("first_g_count", bus.count, D_G);
    check("first_g_lights", bus.lights, LT_GREEN);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e, a;
    bit await_load;
    int want;
    await_load = 1'b0;
    want = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        await_load = 1'b0;
      end else begin
        if (await_load) begin
          check("load_count", bus.count, want);
          await_load = 1'b0;
        end
        if (bus.pulse) begin
          if (load_q.size() == 0) check("load_expected", 0, 1);
          else begin
            want = load_q.pop_front();
            await_load = 1'b1;
          end
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a = {bus.pulse, bus.state, bus.specific, bus.count, bus.lights, bus.walk};
          n_checks++;
          if (a === e) n_pass++;
          else $display("FAIL cycle t=%0t pulse/state/spec/count/lights/walk got %h expected %h",
                        $time, a, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    bus.tick = 1'b0;
    bus.req  = 1'b0;
    apply_reset();
    boot_sequence();

    // Full cycle without requests, back into green
    repeat (D_G + D_A + D_E + D_L) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("cycle_g_state", bus.state, ST_G);
    check("cycle_g_count", bus.count, D_G);

    // Request pulsed in green at count 25: preempt at 20, amber 22
    for (int i = 0; i < 2000 && !(m_idx == 0 && m_count == 25 && !m_loading); i++)
      cycle((i % 4) == 3, 1'b0);
    #1 check("g25_count", bus.count, 25);
    cycle(1'b0, 1'b1);
    repeat (6) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("preempt_state", bus.state, ST_A);
    check("preempt_count", bus.count, D_AS);
    check("preempt_specific", bus.specific, 1);
    repeat (D_AS) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("preempt_e_state", bus.state, ST_E);
    check("preempt_e_specific", bus.specific, 0);
    check("preempt_e_walk", bus.walk, 1);

    // Request just after amber's load: amber keeps 15
    for (int i = 0; i < 2000 && !(m_idx == 1 && m_count == D_A && !m_loading); i++)
      cycle((i % 4) == 3, 1'b0);
    #1 check("late_a_count", bus.count, D_A);
    cycle(1'b0, 1'b1);
    #1 check("late_a_specific", bus.specific, 1);
    repeat (D_A) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("late_e_state", bus.state, ST_E);
    check("late_e_specific", bus.specific, 0);
    repeat (D_E + D_L) sec(1'b0);
    cycle(1'b0, 1'b0);
    repeat (D_G - PREEMPT) sec(1'b0);
    #1 check("no_preempt_state", bus.state, ST_G);
    check("no_preempt_count", bus.count, PREEMPT);

    // Tick during the load pulse, then req on the E-entry edge
    for (int i = 0; i < 2000 && !(m_idx == 1 && m_loading); i++)
      cycle((i % 4) == 3, 1'b0);
    cycle(1'b1, 1'b0);
    #1 check("tick_on_pulse_count", bus.count, D_A);
    repeat (D_A - 1) sec(1'b0);
    sec(1'b1);
    cycle(1'b0, 1'b0);
    #1 check("e_entry_req_state", bus.state, ST_E);
    check("e_entry_req_specific", bus.specific, 1);
    repeat (D_E + D_L) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("carry_g_specific", bus.specific, 0);
    repeat (D_G - PREEMPT + 1) sec(1'b0);
    cycle(1'b0, 1'b0);
    #1 check("carry_preempt_state", bus.state, ST_A);
    check("carry_preempt_count", bus.count, D_AS);

    // Reset in the middle of amber, then a clean restart
    for (int i = 0; i < 2000 && !(m_idx == 1 && m_count == 7 && !m_loading); i++)
      cycle((i % 4) == 3, 1'b0);
    #1 check("mid_a_count", bus.count, 7);
    apply_reset();
    boot_sequence();

    // Random ticks and requests
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
    repeat (4) cycle(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
